// File: rtl/mod_counter.sv
// mod_counter: parametrised up/down counter with wrap or saturate ends,
// synchronous clear/load and registered terminal-count / wrap pulses.
//
// Parameters: WIDTH (2..32), MAX_VAL (1..2^WIDTH-1), PRESCALE (>=1, prescaler only)
// Optional feature: define MOD_COUNTER_PRESCALE_EN to compile in a prescaler
//   so that only every PRESCALE-th enabled cycle produces a step.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   clear     synchronous clear to 0 (beats load and step)
//   load      synchronous load of min(load_val, MAX_VAL) (beats step)
//   load_val  value to load
//   en        count enable
//   dir       1 = up, 0 = down
//   wrap_mode 1 = wrap at range ends, 0 = saturate
//   cnt       registered count
//   tc        registered pulse: a step landed on the terminal value
//   wrap_p    registered pulse: a step wrapped
//   at_max    cnt == MAX_VAL (combinational)
//   at_min    cnt == 0 (combinational)
module mod_counter #(
  parameter int unsigned WIDTH    = 7,
  parameter int unsigned MAX_VAL  = 100,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  input  logic             wrap_mode,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             wrap_p,
  output logic             at_max,
  output logic             at_min
);

  // Reject illegal configurations at elaboration.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("mod_counter: WIDTH out of range");
  end
  if (MAX_VAL < 1 || (WIDTH < 32 && MAX_VAL > (32'd1 << WIDTH) - 1)) begin : g_bad_max
    $error("mod_counter: MAX_VAL out of range");
  end
  if (PRESCALE < 1) begin : g_bad_pre
    $error("mod_counter: PRESCALE must be at least 1");
  end

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

  logic             step;
  logic [WIDTH-1:0] cnt_nxt;
  logic             tc_nxt;
  logic             wrap_nxt;

`ifdef MOD_COUNTER_PRESCALE_EN
  // Counts enabled cycles 0..PRESCALE-1; the step fires on the last one.
  localparam int unsigned    PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PTOP = PW'(PRESCALE - 1);

  logic [PW-1:0] pre;
  logic [PW-1:0] pre_nxt;

  assign step = en && (pre == PTOP);

  always_comb begin
    pre_nxt = pre;
    if (clear || load)
      pre_nxt = '0;
    else if (en)
      pre_nxt = (pre == PTOP) ? '0 : pre + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre <= '0;
    else     pre <= pre_nxt;
  end
`else
  assign step = en;
`endif

  // Pulses default low so they only last the cycle after a qualifying step.
  always_comb begin
    cnt_nxt  = cnt;
    tc_nxt   = 1'b0;
    wrap_nxt = 1'b0;
    if (clear) begin
      cnt_nxt = '0;
    end else if (load) begin
      cnt_nxt = (load_val > MAXV) ? MAXV : load_val;
    end else if (step) begin
      if (dir) begin
        if (cnt < MAXV) begin
          cnt_nxt = cnt + 1'b1;
          tc_nxt  = (cnt + 1'b1 == MAXV);
        end else if (wrap_mode) begin
          cnt_nxt  = '0;
          wrap_nxt = 1'b1;
        end
      end else begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
          tc_nxt  = (cnt == WIDTH'(1));
        end else if (wrap_mode) begin
          cnt_nxt  = MAXV;
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      tc     <= 1'b0;
      wrap_p <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      tc     <= tc_nxt;
      wrap_p <= wrap_nxt;
    end
  end

  assign at_max = (cnt == MAXV);
  assign at_min = (cnt == '0);

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter. Main instance uses PRESCALE=1 so its
// behaviour is the same with or without the prescaler compiled in; a second
// instance with PRESCALE=4 shares the inputs and exercises the prescaler.
module tb_mod_counter;
  localparam int W = 7;
  localparam int M = 100;

  logic         clk = 1'b0;
  logic         rst, clear, load, en, dir, wrap_mode;
  logic [W-1:0] load_val;
  logic [W-1:0] cnt, cnt_ps;
  logic         tc, wrap_p, at_max, at_min;
  logic         tc_ps, wrap_ps, at_max_ps, at_min_ps;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(W), .MAX_VAL(M), .PRESCALE(1)) dut (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
    .en(en), .dir(dir), .wrap_mode(wrap_mode),
    .cnt(cnt), .tc(tc), .wrap_p(wrap_p), .at_max(at_max), .at_min(at_min)
  );

  mod_counter #(.WIDTH(W), .MAX_VAL(M), .PRESCALE(4)) dut_ps (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
    .en(en), .dir(dir), .wrap_mode(wrap_mode),
    .cnt(cnt_ps), .tc(tc_ps), .wrap_p(wrap_ps), .at_max(at_max_ps), .at_min(at_min_ps)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int c, input bit t, input bit w);
    chk({tag, ".cnt"}, 32'(cnt), 32'(c));
    chk({tag, ".tc"}, 32'(tc), 32'(t));
    chk({tag, ".wrap_p"}, 32'(wrap_p), 32'(w));
  endtask

  int tc_count;

  initial begin
    rst = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0;
    en = 1'b0; dir = 1'b1; wrap_mode = 1'b0;

    // Reset state
    tick(); tick();
    chk_state("reset", 0, 0, 0);
    chk("reset.at_min", 32'(at_min), 32'd1);
    chk("reset.at_max", 32'(at_max), 32'd0);

    // Saturating count up for 105 edges
    rst = 1'b0; en = 1'b1; dir = 1'b1; wrap_mode = 1'b0;
    tc_count = 0;
    for (int i = 1; i <= 105; i++) begin
      tick();
      if (tc) tc_count++;
      chk($sformatf("sat%0d", i), 32'(cnt), 32'((i < M) ? i : M));
      chk($sformatf("sat%0d.tc", i), 32'(tc), 32'(i == M));
      chk($sformatf("sat%0d.wrap", i), 32'(wrap_p), 32'd0);
    end
    chk("sat.tc_count", 32'(tc_count), 32'd1);
    chk("sat.at_max", 32'(at_max), 32'd1);

    // Wrap up then down
    wrap_mode = 1'b1; load = 1'b1; load_val = 7'd99;
    tick(); chk_state("wrap.load99", 99, 0, 0);
    load = 1'b0;
    tick(); chk_state("wrap.up100", 100, 1, 0);
    tick(); chk_state("wrap.up0", 0, 0, 1);
    chk("wrap.at_min", 32'(at_min), 32'd1);
    tick(); chk_state("wrap.up1", 1, 0, 0);
    dir = 1'b0;
    tick(); chk_state("wrap.dn0", 0, 1, 0);
    tick(); chk_state("wrap.dn100", 100, 0, 1);
    tick(); chk_state("wrap.dn99", 99, 0, 0);

    // Saturate at the bottom going down
    wrap_mode = 1'b0; clear = 1'b1;
    tick(); chk_state("satdn.clear", 0, 0, 0);
    clear = 1'b0;
    tick(); chk_state("satdn.hold", 0, 0, 0);

    // Priority: clear over load over step
    dir = 1'b1; clear = 1'b1; load = 1'b1; load_val = 7'd50;
    tick(); chk_state("prio.clear", 0, 0, 0);
    clear = 1'b0;
    tick(); chk_state("prio.load50", 50, 0, 0);
    load_val = 7'd127;
    tick(); chk_state("prio.clamp", 100, 0, 0);
    load = 1'b0;
    tick(); chk_state("prio.holdmax", 100, 0, 0);

    // Async reset mid-cycle at cnt=37
    en = 1'b0; load = 1'b1; load_val = 7'd37;
    tick(); load = 1'b0;
    tick(); chk_state("arst.pre", 37, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk_state("arst.now", 0, 0, 0);
    chk("arst.at_min", 32'(at_min), 32'd1);
    #1 rst = 1'b0;
    tick(); chk_state("arst.idle", 0, 0, 0);
    en = 1'b1;
    tick(); chk_state("arst.resume", 1, 0, 0);

    // Prescaler: 12 enabled cycles
    en = 1'b0; clear = 1'b1;
    tick(); clear = 1'b0;
    chk("ps.clear", 32'(cnt_ps), 32'd0);
    en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
`ifdef MOD_COUNTER_PRESCALE_EN
      chk($sformatf("ps.run%0d", i), 32'(cnt_ps), 32'(i / 4));
`else
      chk($sformatf("ps.run%0d", i), 32'(cnt_ps), 32'(i));
`endif
    end

    // Prescaler: gap of 2 disabled cycles delays the step by 2
    en = 1'b0; clear = 1'b1;
    tick(); clear = 1'b0; en = 1'b1;
    tick(); tick();
    en = 1'b0;
    tick(); tick();
    en = 1'b1;
    tick();
`ifdef MOD_COUNTER_PRESCALE_EN
    chk("ps.gap5", 32'(cnt_ps), 32'd0);
`else
    chk("ps.gap5", 32'(cnt_ps), 32'd3);
`endif
    tick();
`ifdef MOD_COUNTER_PRESCALE_EN
    chk("ps.gap6", 32'(cnt_ps), 32'd1);
`else
    chk("ps.gap6", 32'(cnt_ps), 32'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
